// File: rtl/z80_bus_arbiter.sv
// Bus arbiter between a tv80s core and a DMA requester: BUSRQ/BUSAK handshake,
// a per-grant hold limit, a CPU holdoff window after each release, and the address/data/strobe mux.
module z80_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 100,
    parameter int unsigned CPU_MIN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_do,
    input  logic        dma_mreq,
    input  logic        dma_we,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_do,
    output logic        bus_mreq_n,
    output logic        bus_iorq_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    output logic        dma_forced
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GRANT   = 3'd2,
        S_RELEASE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 32'd1);
    localparam logic [15:0] OFF_LOAD  = 16'(CPU_MIN);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] off_q, off_d;
    logic        forced_d;
    logic        busrq_n_q, gnt_q, forced_q;

    // Next-state logic; the abort checks are ordered so a simultaneous
    // withdrawal or lost acknowledge suppresses the forced-release pulse.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        off_d    = off_q;
        forced_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dma_req) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (!cpu_busak_n) begin
                    if (dma_req) begin
                        state_d = S_GRANT;
                        hold_d  = 16'd0;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_GRANT: begin
                if (cpu_busak_n || !dma_req) begin
                    state_d = S_RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d  = S_RELEASE;
                    forced_d = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_RELEASE: begin
                if (cpu_busak_n) begin
                    if (OFF_LOAD == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLDOFF;
                        off_d   = OFF_LOAD;
                    end
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_HOLDOFF: begin
                off_d = off_q - 16'd1;
                if (off_q <= 16'd1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hold_q    <= 16'd0;
            off_q     <= 16'd0;
            busrq_n_q <= 1'b1;
            gnt_q     <= 1'b0;
            forced_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            off_q     <= off_d;
            busrq_n_q <= !((state_d == S_REQ) || (state_d == S_GRANT));
            gnt_q     <= (state_d == S_GRANT);
            forced_q  <= forced_d;
        end
    end

    assign cpu_busrq_n = busrq_n_q;
    assign dma_gnt     = gnt_q;
    assign dma_forced  = forced_q;

    // Bus mux follows the registered grant; DMA never drives IO cycles.
    always_comb begin
        if (gnt_q) begin
            bus_a      = dma_a;
            bus_do     = dma_do;
            bus_mreq_n = ~dma_mreq;
            bus_iorq_n = 1'b1;
            bus_rd_n   = ~(dma_mreq & ~dma_we);
            bus_wr_n   = ~(dma_mreq & dma_we);
        end else begin
            bus_a      = cpu_a;
            bus_do     = cpu_do;
            bus_mreq_n = cpu_mreq_n;
            bus_iorq_n = cpu_iorq_n;
            bus_rd_n   = cpu_rd_n;
            bus_wr_n   = cpu_wr_n;
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Self-checking bench for z80_bus_arbiter: mux vector table plus handshake sequences,
// with expectations queued at drive time and popped when the outputs are sampled.
module tb_z80_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_busrq_n, cpu_busak_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic        dma_req, dma_gnt;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic        dma_mreq, dma_we;
    logic [15:0] bus_a;
    logic [7:0]  bus_do;
    logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
    logic        dma_forced;

    logic [7:0]  mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    z80_bus_arbiter #(.HOLD_MAX(100), .CPU_MIN(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
        .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .dma_req(dma_req), .dma_gnt(dma_gnt),
        .dma_a(dma_a), .dma_do(dma_do),
        .dma_mreq(dma_mreq), .dma_we(dma_we),
        .bus_a(bus_a), .bus_do(bus_do),
        .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n),
        .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .dma_forced(dma_forced)
    );

    always #5 clk = ~clk;

    // Simple memory on the muxed bus.
    always @(posedge clk) begin
        if (!bus_mreq_n && !bus_wr_n) mem[bus_a] <= bus_do;
    end

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        gnt;
        logic [15:0] ca;
        logic [7:0]  cd;
        logic [3:0]  cs;   // {mreq_n, iorq_n, rd_n, wr_n}
        logic [15:0] da;
        logic [7:0]  dd;
        logic        dm;
        logic        dw;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic [3:0]  es;
    } vec_t;
    vec_t tbl[8];

    task automatic expect_v(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic got(input logic [31:0] act);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %0h, no expectation queued", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        cpu_a = v.ca; cpu_do = v.cd;
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n} = v.cs;
        dma_a = v.da; dma_do = v.dd; dma_mreq = v.dm; dma_we = v.dw;
        expect_v($sformatf("mux%0d_a", idx), {16'd0, v.ea});
        expect_v($sformatf("mux%0d_do", idx), {24'd0, v.ed});
        expect_v($sformatf("mux%0d_strb", idx), {28'd0, v.es});
        #1;
        got({16'd0, bus_a});
        got({24'd0, bus_do});
        got({28'd0, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n});
    endtask

    initial begin
        int n;
        int gcnt;
        int fcnt;
        logic gseen;

        tbl[0] = '{1'b0, 16'h0000, 8'h00, 4'b1111, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 16'h0000, 8'h00, 4'b1111};
        tbl[1] = '{1'b0, 16'h1234, 8'hA5, 4'b0101, 16'hBEEF, 8'h11, 1'b1, 1'b0, 16'h1234, 8'hA5, 4'b0101};
        tbl[2] = '{1'b0, 16'hC000, 8'h3C, 4'b1010, 16'h5555, 8'h22, 1'b1, 1'b1, 16'hC000, 8'h3C, 4'b1010};
        tbl[3] = '{1'b0, 16'hFFFF, 8'hFF, 4'b0110, 16'h0001, 8'h33, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 4'b0110};
        tbl[4] = '{1'b1, 16'h1111, 8'h22, 4'b0000, 16'h4000, 8'h77, 1'b1, 1'b0, 16'h4000, 8'h77, 4'b0101};
        tbl[5] = '{1'b1, 16'h2222, 8'h33, 4'b0000, 16'h1234, 8'hC3, 1'b1, 1'b1, 16'h1234, 8'hC3, 4'b0110};
        tbl[6] = '{1'b1, 16'h3333, 8'h44, 4'b0000, 16'hABCD, 8'h00, 1'b0, 1'b1, 16'hABCD, 8'h00, 4'b1111};
        tbl[7] = '{1'b1, 16'h0000, 8'h00, 4'b0000, 16'h0001, 8'h80, 1'b0, 1'b0, 16'h0001, 8'h80, 4'b1111};

        reset = 1'b1; cpu_busak_n = 1'b1; dma_req = 1'b0;
        cpu_a = 16'h0000; cpu_do = 8'h00;
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n} = 4'b1111;
        dma_a = 16'h0000; dma_do = 8'h00; dma_mreq = 1'b0; dma_we = 1'b0;
        step(); step();
        expect_v("rst_busrq_n", 32'd1); expect_v("rst_gnt", 32'd0); expect_v("rst_forced", 32'd0);
        got({31'd0, cpu_busrq_n}); got({31'd0, dma_gnt}); got({31'd0, dma_forced});
        reset = 1'b0;

        for (int i = 0; i < 8; i++) if (!tbl[i].gnt) apply_vec(tbl[i], i);
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n} = 4'b1111;

        // Basic grant with a DMA write
        dma_req = 1'b1;
        expect_v("req_busrq_low", 32'd0); expect_v("req_no_gnt", 32'd0);
        step();
        got({31'd0, cpu_busrq_n}); got({31'd0, dma_gnt});
        step(); step();
        expect_v("wait_ack_no_gnt", 32'd0);
        got({31'd0, dma_gnt});
        cpu_busak_n = 1'b0;
        expect_v("gnt_after_ack", 32'd1);
        step();
        got({31'd0, dma_gnt});
        dma_a = 16'h8000; dma_do = 8'h5A; dma_mreq = 1'b1; dma_we = 1'b1;
        expect_v("dma_wr_a", 32'h8000); expect_v("dma_wr_n", 32'd0);
        #1;
        got({16'd0, bus_a}); got({31'd0, bus_wr_n});
        step();
        for (int i = 0; i < 8; i++) if (tbl[i].gnt) begin apply_vec(tbl[i], i); step(); end
        dma_mreq = 1'b0; dma_req = 1'b0;
        expect_v("rel_gnt", 32'd0); expect_v("rel_busrq_n", 32'd1); expect_v("rel_forced", 32'd0);
        step();
        got({31'd0, dma_gnt}); got({31'd0, cpu_busrq_n}); got({31'd0, dma_forced});
        expect_v("mem_8000", 32'h5A); expect_v("mem_1234", 32'hC3);
        got({24'd0, mem[16'h8000]}); got({24'd0, mem[16'h1234]});
        step();
        cpu_busak_n = 1'b1;
        step();

        // Fairness: cycles from busak_n high to the next request
        dma_req = 1'b1;
        expect_v("holdoff_cycles", 32'd17);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!cpu_busrq_n) begin n = i; break; end
        end
        got(n);

        // Hold limit with dma_req held high
        cpu_busak_n = 1'b0;
        step();
        gcnt = 0; fcnt = 0;
        for (int i = 0; i < 120; i++) begin
            gcnt += int'(dma_gnt);
            fcnt += int'(dma_forced);
            step();
        end
        expect_v("hold_gnt_cycles", 32'd100); expect_v("hold_forced_pulses", 32'd1);
        expect_v("hold_busrq_n", 32'd1);
        got(gcnt); got(fcnt); got({31'd0, cpu_busrq_n});
        cpu_busak_n = 1'b1; dma_req = 1'b0;
        repeat (20) step();

        // Withdrawn request
        dma_req = 1'b1;
        step();
        expect_v("wd_req_entered", 32'd0);
        got({31'd0, cpu_busrq_n});
        dma_req = 1'b0;
        gseen = dma_gnt;
        step(); gseen |= dma_gnt;
        step(); gseen |= dma_gnt;
        cpu_busak_n = 1'b0;
        step(); gseen |= dma_gnt;
        expect_v("wd_busrq_released", 32'd1); expect_v("wd_never_gnt", 32'd0);
        got({31'd0, cpu_busrq_n}); got({31'd0, gseen});
        cpu_busak_n = 1'b1;
        step();
        repeat (20) step();

        // Acknowledge dropped mid-grant
        dma_req = 1'b1;
        step();
        cpu_busak_n = 1'b0;
        step(); step(); step(); step();
        cpu_busak_n = 1'b1;
        expect_v("viol_gnt", 32'd0); expect_v("viol_forced", 32'd0); expect_v("viol_busrq_n", 32'd1);
        step();
        got({31'd0, dma_gnt}); got({31'd0, dma_forced}); got({31'd0, cpu_busrq_n});
        step();
        dma_req = 1'b0;
        repeat (20) step();

        // Reset at grant cycle 10, then immediate re-request
        dma_req = 1'b1;
        step();
        cpu_busak_n = 1'b0;
        step();
        repeat (9) step();
        expect_v("pre_rst_gnt", 32'd1);
        got({31'd0, dma_gnt});
        reset = 1'b1;
        expect_v("mid_rst_gnt", 32'd0); expect_v("mid_rst_busrq_n", 32'd1); expect_v("mid_rst_forced", 32'd0);
        step();
        got({31'd0, dma_gnt}); got({31'd0, cpu_busrq_n}); got({31'd0, dma_forced});
        reset = 1'b0; cpu_busak_n = 1'b1;
        expect_v("post_rst_req", 32'd0);
        step();
        got({31'd0, cpu_busrq_n});

        // Withdrawal on the final allowed grant cycle: no forced pulse
        cpu_busak_n = 1'b0;
        step();
        repeat (99) step();
        expect_v("last_cycle_gnt", 32'd1);
        got({31'd0, dma_gnt});
        dma_req = 1'b0;
        expect_v("both_gnt", 32'd0); expect_v("both_forced", 32'd0); expect_v("both_forced_late", 32'd0);
        step();
        got({31'd0, dma_gnt}); got({31'd0, dma_forced});
        step();
        got({31'd0, dma_forced});

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 100: maximum number of consecutive cycles the DMA requester SHALL own the bus per grant (legal range 1..65535).
REQ-002 Parameter CPU_MIN, default 16: number of cycles the CPU SHALL own the bus after each release before a new request is issued (legal range 0..65535).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 cpu_busrq_n  out  1  registered bus request to the tv80s core.
REQ-006 cpu_busak_n  in  1  bus acknowledge from the core.
REQ-007 cpu_a, cpu_do  in  16, 8  CPU address and write data.
REQ-008 cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n  in  1 each  CPU strobes, active-low.
REQ-009 dma_req  in  1  DMA requests the bus while high (level).
REQ-010 dma_gnt  out  1  registered; DMA owns the bus while high.
REQ-011 dma_a, dma_do  in  16, 8  DMA address and write data.
REQ-012 dma_mreq, dma_we  in  1 each  DMA memory cycle strobe and write select, active-high.
REQ-013 bus_a, bus_do  out  16, 8  muxed address and write data to memory/IO.
REQ-014 bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n  out  1 each  muxed strobes, active-low.
REQ-015 dma_forced  out  1  one-cycle registered pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-016 FSM states: IDLE, REQ, GRANT, RELEASE, HOLDOFF; cpu_busrq_n SHALL be 0 exactly in REQ and GRANT.
REQ-017 IDLE: dma_req=1 -> REQ at the next edge; cpu_busrq_n goes low in that same edge.
REQ-018 REQ: stay until cpu_busak_n=0 is sampled; then dma_req=1 -> GRANT, dma_req=0 -> RELEASE (request withdrawn, no grant).
REQ-019 GRANT: dma_gnt=1 from the edge entering GRANT; 16-bit hold counter cleared on entry, increments each GRANT cycle.
REQ-020 GRANT exit -> RELEASE when dma_req=0, or when hold counter = HOLD_MAX-1 (exactly HOLD_MAX GRANT cycles); the limit case SHALL pulse dma_forced for one cycle; if both occur in the same cycle, dma_forced SHALL be 0.
REQ-021 RELEASE: dma_gnt=0, cpu_busrq_n=1; stay until cpu_busak_n=1 is sampled, then -> HOLDOFF with the counter loaded with CPU_MIN, or -> IDLE directly if CPU_MIN=0.
REQ-022 HOLDOFF: counter decrements each cycle; -> IDLE when it reaches 1; dma_req is ignored in HOLDOFF.
REQ-023 Mux is combinational on dma_gnt: 0 -> bus_* = cpu_*; 1 -> bus_a=dma_a, bus_do=dma_do, bus_mreq_n=~dma_mreq, bus_rd_n=~(dma_mreq&~dma_we), bus_wr_n=~(dma_mreq&dma_we), bus_iorq_n=1.
REQ-024 dma_gnt SHALL never be 1 while cpu_busak_n=1 was the last sampled value (no grant without acknowledge).
REQ-025 cpu_busak_n rising while in GRANT (protocol violation) SHALL force RELEASE at the next edge, with dma_forced=0.

Reset
REQ-026 With reset=1 at an edge: state=IDLE, cpu_busrq_n=1, dma_gnt=0, dma_forced=0, both counters=0; this applies from any state, including mid-GRANT.
REQ-027 After reset deasserts, the first request SHALL be accepted without a CPU_MIN holdoff.

Verification
REQ-028 Basic grant: dma_req=1 at cycle 0, core acks after its current M-cycle -> cpu_busrq_n=0 at cycle 1, dma_gnt=1 one edge after busak_n=0 sampled; DMA write 0x5A to 0x8000 lands in memory.
REQ-029 Hold limit: HOLD_MAX=100, dma_req held high -> dma_gnt high exactly 100 cycles, dma_forced one pulse, then cpu_busrq_n=1 and the CPU resumes executing (PC advances).
REQ-030 Fairness: CPU_MIN=16, dma_req held high -> the next cpu_busrq_n falling edge occurs no earlier than 17 cycles after busak_n returns high.
REQ-031 Withdrawn request: dma_req pulses for 1 cycle -> REQ entered, dma_gnt stays 0 throughout, cpu_busrq_n released after ack, CPU registers unchanged except PC/R progress.
REQ-032 Reset mid-GRANT: reset asserted at grant cycle 10 -> dma_gnt=0 and cpu_busrq_n=1 after that edge; a subsequent program (JR 0x40 at 0x0000) reaches PC=0x0042.
